// File: rtl/iobus_decoder_pkg.sv
// iobus_decoder_pkg
//   Shared SoC definitions for the ExtIO bus: the slave index enumeration and
//   the Base/Length of every memory-mapped ExtIO region, plus a small range
//   helper used by the address decoder.
package iobus_decoder_pkg;

  // Slave index as seen on the one-hot slv_* vectors.
  typedef enum logic [1:0] {
    SLV_GPIO = 2'd0,
    SLV_ETH  = 2'd1,
    SLV_SPI  = 2'd2,
    SLV_UART = 2'd3
  } io_slave_e;

  localparam int unsigned NrIoRegions = 4;

  localparam logic [63:0] UartBase = 64'h0000_0000_4100_0000;
  localparam logic [63:0] UartLen  = 64'h0000_0000_0000_1000;
  localparam logic [63:0] SpiBase  = 64'h0000_0000_4200_0000;
  localparam logic [63:0] SpiLen   = 64'h0000_0000_0080_0000;
  localparam logic [63:0] EthBase  = 64'h0000_0000_4300_0000;
  localparam logic [63:0] EthLen   = 64'h0000_0000_0001_0000;
  localparam logic [63:0] GpioBase = 64'h0000_0000_4400_0000;
  localparam logic [63:0] GpioLen  = 64'h0000_0000_0000_1000;

  // Half-open interval test: base <= addr < base + len.
  function automatic logic in_region(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] len);
    return (addr >= base) && (addr < (base + len));
  endfunction

endpackage

// File: rtl/iobus_addr_decode.sv
// iobus_addr_decode
//   Purely combinational ExtIO address decoder.
//   Ports:
//     addr_i  in  64  full request address
//     hit_o   out 1   address falls inside one of the ExtIO regions
//     idx_o   out io_slave_e  index of the matching slave (GPIO when no hit)
module iobus_addr_decode
  import iobus_decoder_pkg::*;
(
  input  logic [63:0] addr_i,
  output logic        hit_o,
  output io_slave_e   idx_o
);

  // Regions do not overlap, so the priority order below is irrelevant to
  // the result; it only keeps the logic a simple chain.
  always_comb begin
    hit_o = 1'b1;
    idx_o = SLV_GPIO;
    if (in_region(addr_i, UartBase, UartLen)) begin
      idx_o = SLV_UART;
    end else if (in_region(addr_i, SpiBase, SpiLen)) begin
      idx_o = SLV_SPI;
    end else if (in_region(addr_i, EthBase, EthLen)) begin
      idx_o = SLV_ETH;
    end else if (in_region(addr_i, GpioBase, GpioLen)) begin
      idx_o = SLV_GPIO;
    end else begin
      hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/iobus_decoder.sv
// iobus_decoder
//   Bridges one upstream ExtIO request port to NrIoSlaves downstream slaves
//   (GPIO=0, Ethernet=1, SPI=2, UART=3). One transaction is in flight at a
//   time; unmapped addresses and unresponsive slaves return err=1, rdata=0.
//
//   Handshake rule for every valid/ready pair on this block: a transfer
//   happens on a rising clk edge where valid and ready are both 1; once
//   valid is raised, it and its payload stay stable until that transfer,
//   and valid never waits on ready.
//
//   Ports:
//     clk_i, rst_ni                      clock, async active-low reset
//     req_valid_i / req_ready_o          upstream request handshake
//     req_addr_i/we_i/wdata_i/be_i       upstream request payload
//     resp_valid_o / resp_ready_i        upstream response handshake
//     resp_rdata_o, resp_err_o           upstream response payload
//     slv_req_valid_o / slv_req_ready_i  one-hot downstream request
//     slv_addr_o/we_o/wdata_o/be_o       request payload, broadcast
//     slv_resp_valid_i / slv_resp_ready_o, slv_rdata_i, slv_err_i
//                                        per-slave downstream response
//     dbg_state_o                        current FSM state encoding
module iobus_decoder
  import iobus_decoder_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 256,
  parameter int unsigned NrIoSlaves    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [63:0]                 req_addr_i,
  input  logic                        req_we_i,
  input  logic [63:0]                 req_wdata_i,
  input  logic [7:0]                  req_be_i,
  output logic                        resp_valid_o,
  input  logic                        resp_ready_i,
  output logic [63:0]                 resp_rdata_o,
  output logic                        resp_err_o,
  output logic [NrIoSlaves-1:0]       slv_req_valid_o,
  input  logic [NrIoSlaves-1:0]       slv_req_ready_i,
  output logic [63:0]                 slv_addr_o,
  output logic                        slv_we_o,
  output logic [63:0]                 slv_wdata_o,
  output logic [7:0]                  slv_be_o,
  input  logic [NrIoSlaves-1:0]       slv_resp_valid_i,
  output logic [NrIoSlaves-1:0]       slv_resp_ready_o,
  input  logic [NrIoSlaves-1:0][63:0] slv_rdata_i,
  input  logic [NrIoSlaves-1:0]       slv_err_i,
  output logic [1:0]                  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // The counter never needs to hold more than TimeoutCycles, and is kept at
  // least 8 bits wide.
  localparam int unsigned CntRaw  = $clog2(TimeoutCycles + 1);
  localparam int unsigned CntW    = (CntRaw > 8) ? CntRaw : 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  state_e          state_q, state_d;
  logic [63:0]     addr_q, addr_d;
  logic            we_q, we_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [7:0]      be_q, be_d;
  io_slave_e       sel_q, sel_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic      dec_hit;
  io_slave_e dec_idx;
  logic      dec_hit_ok;

  logic        sel_req_ready;
  logic        sel_resp_valid;
  logic [63:0] sel_rdata;
  logic        sel_err;
  logic        timed_out;

  iobus_addr_decode u_addr_decode (
    .addr_i (req_addr_i),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  // A decoded region without a physical slave port is treated as a miss.
  assign dec_hit_ok = dec_hit && (32'(dec_idx) < NrIoSlaves);

  // Only the selected slave's inputs are ever looked at.
  always_comb begin
    sel_req_ready  = 1'b0;
    sel_resp_valid = 1'b0;
    sel_rdata      = '0;
    sel_err        = 1'b0;
    for (int unsigned i = 0; i < NrIoSlaves; i++) begin
      if (32'(sel_q) == i) begin
        sel_req_ready  = slv_req_ready_i[i];
        sel_resp_valid = slv_resp_valid_i[i];
        sel_rdata      = slv_rdata_i[i];
        sel_err        = slv_err_i[i];
      end
    end
  end

  assign timed_out = (cnt_q >= CntLast);

  // Next-state and upstream outputs. In ISSUE/WAIT the completion test is
  // checked before the timeout so completion wins a same-cycle tie.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          we_d    = req_we_i;
          wdata_d = req_wdata_i;
          be_d    = req_be_i;
          sel_d   = dec_idx;
          cnt_d   = '0;
          if (dec_hit_ok) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end

      ST_ISSUE: begin
        cnt_d = cnt_q + CntW'(1);
        if (sel_req_ready) begin
          state_d = ST_WAIT;
        end else if (timed_out) begin
          state_d = ST_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + CntW'(1);
        if (sel_resp_valid) begin
          state_d = ST_RESP;
          rdata_d = sel_rdata;
          err_d   = sel_err;
        end else if (timed_out) begin
          state_d = ST_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end

      ST_RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Downstream handshake outputs follow the state directly, so leaving
  // ISSUE/WAIT on a timeout drops them in the same edge.
  always_comb begin
    slv_req_valid_o  = '0;
    slv_resp_ready_o = '0;
    for (int unsigned i = 0; i < NrIoSlaves; i++) begin
      if (32'(sel_q) == i) begin
        slv_req_valid_o[i]  = (state_q == ST_ISSUE);
        slv_resp_ready_o[i] = (state_q == ST_WAIT);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      sel_q   <= SLV_GPIO;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign slv_addr_o   = addr_q;
  assign slv_we_o     = we_q;
  assign slv_wdata_o  = wdata_q;
  assign slv_be_o     = be_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_iobus_decoder.sv
// tb_iobus_decoder
//   Directed bench for iobus_decoder: expected responses are pushed to a
//   queue when a request is driven and popped when resp_valid_o appears.
module tb_iobus_decoder;

  localparam int TO = 32;
  localparam int NS = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                req_valid_i = 1'b0;
  logic                req_ready_o;
  logic [63:0]         req_addr_i = '0;
  logic                req_we_i = 1'b0;
  logic [63:0]         req_wdata_i = '0;
  logic [7:0]          req_be_i = '0;
  logic                resp_valid_o;
  logic                resp_ready_i = 1'b0;
  logic [63:0]         resp_rdata_o;
  logic                resp_err_o;
  logic [NS-1:0]       slv_req_valid_o;
  logic [NS-1:0]       slv_req_ready_i = '0;
  logic [63:0]         slv_addr_o;
  logic                slv_we_o;
  logic [63:0]         slv_wdata_o;
  logic [7:0]          slv_be_o;
  logic [NS-1:0]       slv_resp_valid_i = '0;
  logic [NS-1:0]       slv_resp_ready_o;
  logic [NS-1:0][63:0] slv_rdata_i = '0;
  logic [NS-1:0]       slv_err_i = '0;
  logic [1:0]          dbg_state_o;

  int checks = 0;
  int failures = 0;
  logic [64:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  iobus_decoder #(
    .TimeoutCycles (TO),
    .NrIoSlaves    (NS)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_addr_i       (req_addr_i),
    .req_we_i         (req_we_i),
    .req_wdata_i      (req_wdata_i),
    .req_be_i         (req_be_i),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready_i),
    .resp_rdata_o     (resp_rdata_o),
    .resp_err_o       (resp_err_o),
    .slv_req_valid_o  (slv_req_valid_o),
    .slv_req_ready_i  (slv_req_ready_i),
    .slv_addr_o       (slv_addr_o),
    .slv_we_o         (slv_we_o),
    .slv_wdata_o      (slv_wdata_o),
    .slv_be_o         (slv_be_o),
    .slv_resp_valid_i (slv_resp_valid_i),
    .slv_resp_ready_o (slv_resp_ready_o),
    .slv_rdata_i      (slv_rdata_i),
    .slv_err_i        (slv_err_i),
    .dbg_state_o      (dbg_state_o)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference address map, written out independently of the RTL package.
  function automatic int ref_slave(input logic [63:0] a);
    if (a >= 64'h4100_0000 && a < 64'h4100_1000) return 3;
    if (a >= 64'h4200_0000 && a < 64'h4280_0000) return 2;
    if (a >= 64'h4300_0000 && a < 64'h4301_0000) return 1;
    if (a >= 64'h4400_0000 && a < 64'h4400_1000) return 0;
    return -1;
  endfunction

  task automatic clear_slaves();
    slv_req_ready_i  = '0;
    slv_resp_valid_i = '0;
    slv_rdata_i      = '0;
    slv_err_i        = '0;
  endtask

  // Random activity on every slave except the selected one.
  task automatic noise_others(input int sel);
    for (int i = 0; i < NS; i++) begin
      if (i != sel) begin
        slv_req_ready_i[i]  = 1'($urandom_range(0, 1));
        slv_resp_valid_i[i] = 1'($urandom_range(0, 1));
        slv_rdata_i[i]      = {$urandom, $urandom};
        slv_err_i[i]        = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // ---------------- driver task ----------------
  // rdly: cycles the slave delays req_ready; sdly: cycles it delays the
  // response once in WAIT (-1 = never responds); hold: cycles resp_ready_i
  // stays low after resp_valid_o rises.
  task automatic run_txn(input string tag, input logic [63:0] addr, input logic we,
                         input logic [63:0] wdata, input logic [7:0] be,
                         input int rdly, input int sdly,
                         input logic [63:0] s_rdata, input logic s_err, input int hold);
    int          es;
    int          exp_lat;
    int          c;
    int          rq_wait;
    int          rs_wait;
    bit          got;
    bit          issued;
    bit          waited;
    logic [3:0]  oh;
    logic [63:0] rd0;
    logic        er0;
    logic [64:0] exp;

    es = ref_slave(addr);
    c = 0; rq_wait = 0; rs_wait = 0; got = 0; issued = 0; waited = 0;
    oh = '0;
    if (es >= 0) oh[es] = 1'b1;
    if (es < 0) begin
      exp_q.push_back({1'b1, 64'h0});
      exp_lat = 1;
    end else if (sdly < 0) begin
      exp_q.push_back({1'b1, 64'h0});
      exp_lat = 1 + TO;
    end else begin
      exp_q.push_back({s_err, s_rdata});
      exp_lat = 3 + rdly + sdly;
    end

    chk({tag, ".req_ready_idle"}, 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_we_i    = we;
    req_wdata_i = wdata;
    req_be_i    = be;
    tick();
    req_valid_i = 1'b0;
    req_addr_i  = {$urandom, $urandom};
    req_wdata_i = {$urandom, $urandom};

    while (!got && c < TO + 20) begin
      c++;
      if (resp_valid_o) begin
        got = 1;
      end else begin
        clear_slaves();
        noise_others(es);
        chk({tag, ".req_ready_busy"}, 64'(req_ready_o), 64'd0);
        if (slv_req_valid_o != '0) begin
          if (!issued) begin
            chk({tag, ".slv_req_valid"}, 64'(slv_req_valid_o), 64'(oh));
            chk({tag, ".slv_addr"}, slv_addr_o, addr);
            chk({tag, ".slv_we"}, 64'(slv_we_o), 64'(we));
            chk({tag, ".slv_wdata"}, slv_wdata_o, wdata);
            chk({tag, ".slv_be"}, 64'(slv_be_o), 64'(be));
          end
          issued = 1;
          if (es >= 0 && rq_wait >= rdly) slv_req_ready_i[es] = 1'b1;
          rq_wait++;
        end
        if (slv_resp_ready_o != '0) begin
          if (!waited) chk({tag, ".slv_resp_ready"}, 64'(slv_resp_ready_o), 64'(oh));
          waited = 1;
          if (es >= 0 && sdly >= 0 && rs_wait >= sdly) begin
            slv_resp_valid_i[es] = 1'b1;
            slv_rdata_i[es]      = s_rdata;
            slv_err_i[es]        = s_err;
          end
          rs_wait++;
        end
        tick();
      end
    end
    clear_slaves();

    chk({tag, ".resp_seen"}, 64'(got), 64'd1);
    chk({tag, ".latency"}, 64'(c), 64'(exp_lat));
    chk({tag, ".issued"}, 64'(issued), 64'(es >= 0));

    exp = exp_q.pop_front();
    if (got) begin
      rd0 = resp_rdata_o;
      er0 = resp_err_o;
      for (int h = 0; h < hold; h++) begin
        tick();
        chk({tag, ".hold_valid"}, 64'(resp_valid_o), 64'd1);
        chk({tag, ".hold_req_ready"}, 64'(req_ready_o), 64'd0);
        chk({tag, ".hold_rdata"}, resp_rdata_o, rd0);
        chk({tag, ".hold_err"}, 64'(resp_err_o), 64'(er0));
      end
      chk({tag, ".rdata"}, resp_rdata_o, exp[63:0]);
      chk({tag, ".err"}, 64'(resp_err_o), 64'(exp[64]));
      resp_ready_i = 1'b1;
      tick();
      resp_ready_i = 1'b0;
      chk({tag, ".resp_drop"}, 64'(resp_valid_o), 64'd0);
      chk({tag, ".back_idle"}, 64'(req_ready_o), 64'd1);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] a;
    int r;

    #1;
    chk("rst.resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst.resp_err", 64'(resp_err_o), 64'd0);
    chk("rst.resp_rdata", resp_rdata_o, 64'd0);
    chk("rst.slv_req_valid", 64'(slv_req_valid_o), 64'd0);
    chk("rst.slv_resp_ready", 64'(slv_resp_ready_o), 64'd0);
    chk("rst.slv_addr", slv_addr_o, 64'd0);
    chk("rst.state", 64'(dbg_state_o), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // UART read, slave answers two cycles into WAIT.
    run_txn("uart_rd", 64'h4100_0010, 1'b0, 64'h0, 8'hff, 0, 2, 64'h55, 1'b0, 0);
    // Unmapped write.
    run_txn("miss_wr", 64'h4500_0000, 1'b1, 64'h1234_5678, 8'h0f, 0, 0, 64'h0, 1'b0, 0);
    // Ethernet upper boundary and one past it.
    run_txn("eth_last", 64'h4300_FFFF, 1'b0, 64'h0, 8'h01, 1, 0, 64'hCAFE_F00D_0000_0001, 1'b0, 0);
    run_txn("eth_past", 64'h4301_0000, 1'b0, 64'h0, 8'h01, 0, 0, 64'h0, 1'b0, 0);
    // Lower boundaries of UART and SPI region end.
    run_txn("uart_base", 64'h4100_0000, 1'b0, 64'h0, 8'hff, 0, 0, 64'hA5A5, 1'b0, 0);
    run_txn("below_uart", 64'h40FF_FFFF, 1'b0, 64'h0, 8'hff, 0, 0, 64'h0, 1'b0, 0);
    run_txn("spi_last", 64'h427F_FFF8, 1'b0, 64'h0, 8'hff, 2, 1, 64'h0BAD_BEEF, 1'b0, 0);

    // GPIO never answers: timeout, then a late response must be ignored.
    run_txn("gpio_to", 64'h4400_0000, 1'b0, 64'h0, 8'hff, 0, -1, 64'h0, 1'b0, 0);
    slv_resp_valid_i[0] = 1'b1;
    slv_rdata_i[0]      = 64'hDEAD;
    slv_req_ready_i[0]  = 1'b1;
    #1;
    chk("late.slv_resp_ready", 64'(slv_resp_ready_o), 64'd0);
    tick();
    chk("late.resp_valid", 64'(resp_valid_o), 64'd0);
    chk("late.req_ready", 64'(req_ready_o), 64'd1);
    clear_slaves();
    run_txn("spi_after_to", 64'h4200_0100, 1'b0, 64'h0, 8'hff, 0, 0, 64'h7777_0000_1111, 1'b0, 0);

    // Back-pressured response with a slave error on a UART write.
    run_txn("uart_hold", 64'h4100_0FFF, 1'b1, 64'hFEED_FACE, 8'h0f, 1, 3, 64'h99, 1'b1, 10);

    // Reset pulsed while in WAIT.
    req_valid_i = 1'b1;
    req_addr_i  = 64'h4300_0040;
    tick();
    req_valid_i = 1'b0;
    slv_req_ready_i[1] = 1'b1;
    #1;
    chk("rstw.issue", 64'(slv_req_valid_o), 64'b0010);
    tick();
    slv_req_ready_i = '0;
    chk("rstw.wait", 64'(slv_resp_ready_o), 64'b0010);
    rst_n = 1'b0;
    slv_resp_valid_i[1] = 1'b1;
    slv_rdata_i[1] = 64'h1;
    #1;
    chk("rstw.resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rstw.slv_resp_ready", 64'(slv_resp_ready_o), 64'd0);
    chk("rstw.slv_req_valid", 64'(slv_req_valid_o), 64'd0);
    chk("rstw.slv_addr", slv_addr_o, 64'd0);
    chk("rstw.resp_rdata", resp_rdata_o, 64'd0);
    chk("rstw.resp_err", 64'(resp_err_o), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    clear_slaves();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstw.no_resp", 64'(resp_valid_o), 64'd0);
      chk("rstw.idle", 64'(req_ready_o), 64'd1);
    end
    run_txn("gpio_after_rst", 64'h4400_0008, 1'b1, 64'h0F0F, 8'h03, 0, 1, 64'h42, 1'b0, 0);

    // A handful of random transactions across the map.
    for (int n = 0; n < 8; n++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: a = 64'h4400_0000 + 64'($urandom_range(0, 32'h0FFF));
        1: a = 64'h4300_0000 + 64'($urandom_range(0, 32'hFFFF));
        2: a = 64'h4200_0000 + 64'($urandom_range(0, 32'h7F_FFFF));
        3: a = 64'h4100_0000 + 64'($urandom_range(0, 32'h0FFF));
        default: a = 64'h4600_0000 + 64'($urandom_range(0, 32'hFFFF));
      endcase
      run_txn("rand", a, 1'($urandom_range(0, 1)), {$urandom, $urandom},
              8'($urandom_range(0, 255)), $urandom_range(0, 3), $urandom_range(0, 3),
              {$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iobus_decoder.md
IOBUS_DECODER -- requirements
Module: iobus_decoder

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 256, giving the max cycles from issue to slave response before an abort.
REQ-002 SHALL have parameter NrIoSlaves, default 4, giving the number of ExtIO slaves (GPIO=0, Ethernet=1, SPI=2, UART=3).
REQ-003 SHALL have port clk_i  in  1  clock; single clock domain.
REQ-004 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req_valid_i in 1 / req_ready_o out 1 for the upstream request handshake from the ExtIO crossbar port.
REQ-006 SHALL have ports req_addr_i in 64, req_we_i in 1, req_wdata_i in 64, req_be_i in 8 for the request payload.
REQ-007 SHALL have ports resp_valid_o out 1 / resp_ready_i in 1, resp_rdata_o out 64, resp_err_o out 1 for the upstream response.
REQ-008 SHALL have ports slv_req_valid_o out NrIoSlaves (one-hot) / slv_req_ready_i in NrIoSlaves for the downstream request.
REQ-009 SHALL have ports slv_addr_o out 64, slv_we_o out 1, slv_wdata_o out 64, slv_be_o out 8, broadcast to all slaves.
REQ-010 SHALL have ports slv_resp_valid_i in NrIoSlaves, slv_resp_ready_o out NrIoSlaves, slv_rdata_i in NrIoSlaves x 64, slv_err_i in NrIoSlaves.

Function
REQ-011 SHALL decode a hit as Base <= addr < Base+Length: UART 0x4100_0000/0x1000, SPI 0x4200_0000/0x80_0000, Ethernet 0x4300_0000/0x1_0000, GPIO 0x4400_0000/0x1000; anything else is a miss.
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, with one outstanding transaction at a time.
REQ-013 IDLE: req_ready_o=1; on req_valid_i&&req_ready_o, register addr/we/wdata/be and the decoded index; go to ISSUE on a hit, or to RESP with err=1, rdata=0 on a miss.
REQ-014 ISSUE: slv_req_valid_o[sel]=1, held stable until slv_req_ready_i[sel]; on the handshake, go to WAIT.
REQ-015 WAIT: slv_resp_ready_o[sel]=1; on slv_resp_valid_i[sel], capture slv_rdata_i[sel] and slv_err_i[sel], then go to RESP.
REQ-016 RESP: resp_valid_o=1 with stable rdata/err until resp_ready_i; then go to IDLE; req_ready_o=0 in every state other than IDLE.
REQ-017 SHALL clear an 8+ bit timeout counter on entry to ISSUE and increment it each cycle in ISSUE/WAIT.
REQ-018 When the counter reaches TimeoutCycles-1 without completion, SHALL drop slv_req_valid_o/slv_resp_ready_o and go to RESP with err=1, rdata=0.
REQ-019 If completion and timeout occur in the same cycle, completion SHALL win.
REQ-020 SHALL ignore slave signals from non-selected slaves, and late responses from an aborted slave, and SHALL keep their ready outputs at 0.
REQ-021 Latency: a hit with slaves ready/responding in the same cycle SHALL give resp_valid_o 3 cycles after request accept; a miss SHALL give resp_valid_o 1 cycle after accept.
REQ-022 slv_addr_o SHALL carry the full registered address, not an offset.

Reset
REQ-023 On rst_ni low, SHALL force state=IDLE, counter=0, all slv_*valid/ready outputs 0, resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, and registered payload 0.
REQ-024 Reset asserted mid-transaction SHALL abandon the transaction, with no response emitted after release.

Structure
REQ-025 Base/Length constants and the slave-index enum SHALL come from the shared SoC package; the FSM state enum SHALL be local.
REQ-026 Address decode SHALL be a combinational sub-module, iobus_addr_decode, producing a hit flag and index.

Verification
REQ-027 Read 0x4100_0010, UART responds rdata=0x55 after 2 cycles -> resp_rdata_o=0x55, resp_err_o=0, slv_req_valid_o=4'b1000.
REQ-028 Write 0x4500_0000 (unmapped) -> no slv_req_valid_o, resp_valid_o 1 cycle after accept, err=1, rdata=0.
REQ-029 Read 0x4300_FFFF vs 0x4301_0000 -> Ethernet selected for the first, miss/err=1 for the second.
REQ-030 GPIO never asserts slv_resp_valid_i -> resp err=1 exactly TimeoutCycles cycles after ISSUE entry; a late GPIO response is ignored and the next request is clean.
REQ-031 resp_ready_i held low 10 cycles in RESP -> resp payload stable, req_ready_o=0 throughout.
REQ-032 rst_ni pulsed low during WAIT -> all outputs at reset values, no spurious resp_valid_o, and the next request completes normally.
